// File: rtl/adder_ripple_pipe.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit ripple per register stage,
// one operation accepted per cycle, fixed latency of WIDTH/CHUNK cycles.
module adder_ripple_pipe #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4   // WIDTH must be an exact multiple of CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    output logic [WIDTH-1:0] q,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / CHUNK;

    // Each stage carries only what is still needed downstream: the finished low
    // sum bits grow by CHUNK per stage while the pending operand bits shrink.
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        localparam int AW = WIDTH - g * CHUNK;
        localparam int SW = (g + 1) * CHUNK;

        logic          v_in;
        logic          c_in;
        logic [AW-1:0] a_in;
        logic [AW-1:0] b_in;
        logic [CHUNK:0] add_w;
        logic [SW-1:0] sum_d;
        logic          carry_d;
        logic          valid_q;
        logic          carry_q;
        logic [SW-1:0] sum_q;

        if (g == 0) begin : g_head
            assign v_in  = in_valid;
            assign a_in  = a;
            assign b_in  = sub ? ~b : b;
            assign c_in  = sub | cin;
            assign sum_d = add_w[CHUNK-1:0];
        end else begin : g_body
            assign v_in  = g_stage[g-1].valid_q;
            assign a_in  = g_stage[g-1].g_fwd.a_q;
            assign b_in  = g_stage[g-1].g_fwd.b_q;
            assign c_in  = g_stage[g-1].carry_q;
            assign sum_d = {add_w[CHUNK-1:0], g_stage[g-1].sum_q};
        end

        assign add_w   = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
                       + {{CHUNK{1'b0}}, c_in};
        assign carry_d = add_w[CHUNK];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else begin
                valid_q <= v_in;
                if (v_in) begin
                    carry_q <= carry_d;
                    sum_q   <= sum_d;
                end
            end
        end

        if (g < STAGES - 1) begin : g_fwd
            logic [AW-CHUNK-1:0] a_q;
            logic [AW-CHUNK-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (v_in) begin
                    a_q <= a_in[AW-1:CHUNK];
                    b_q <= b_in[AW-1:CHUNK];
                end
            end
        end else begin : g_tail
            // Top chunk here holds the registered MSBs of a and of the effective b.
            logic ovf_d;
            logic ovf_q;

            assign ovf_d = (a_in[CHUNK-1] == b_in[CHUNK-1]) &&
                           (add_w[CHUNK-1] != a_in[CHUNK-1]);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (v_in) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign q         = g_stage[STAGES-1].sum_q;
    assign cout      = g_stage[STAGES-1].carry_q;
    assign ovf       = g_stage[STAGES-1].g_tail.ovf_q;

endmodule

// File: tb/tb_adder_ripple_pipe.sv
// Scoreboard bench for adder_ripple_pipe (WIDTH=16, CHUNK=4): directed vectors with
// hand-computed results, issue cycle checked against a 4-cycle latency.
module tb_adder_ripple_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic [15:0] q;
    logic        cout;
    logic        ovf;

    typedef struct {
        logic [15:0] q;
        logic        c;
        logic        o;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] last_q = '0;
    logic        last_c = 1'b0;
    logic        last_o = 1'b0;

    adder_ripple_pipe #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .q         (q),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops on every out_valid, otherwise checks that outputs hold.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_out_valid: got 1, expected 0 (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency_cycle", cyc, e.cyc);
                    chk("q", {16'h0, q}, {16'h0, e.q});
                    chk("cout", {31'h0, cout}, {31'h0, e.c});
                    chk("ovf", {31'h0, ovf}, {31'h0, e.o});
                    last_q = e.q;
                    last_c = e.c;
                    last_o = e.o;
                end
            end else begin
                chk("hold_q", {16'h0, q}, {16'h0, last_q});
                chk("hold_cout", {31'h0, cout}, {31'h0, last_c});
                chk("hold_ovf", {31'h0, ovf}, {31'h0, last_o});
            end
        end
    end

    task automatic drive(input logic [15:0] ta, input logic [15:0] tb_,
                         input logic tc, input logic ts,
                         input logic [15:0] eq, input logic ec, input logic eo,
                         input logic push);
        exp_t e;
        @(negedge clk);
        a        = ta;
        b        = tb_;
        cin      = tc;
        sub      = ts;
        in_valid = 1'b1;
        if (push) begin
            e.q   = eq;
            e.c   = ec;
            e.o   = eo;
            e.cyc = cyc + 4;
            sb.push_back(e);
        end
    endtask

    task automatic op(input logic [15:0] ta, input logic [15:0] tb_,
                      input logic tc, input logic ts,
                      input logic [15:0] eq, input logic ec, input logic eo);
        drive(ta, tb_, tc, ts, eq, ec, eo, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            a        = 16'hDEAD;
            b        = 16'hBEEF;
            cin      = 1'b1;
            sub      = ~sub;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out_valid"}, {31'h0, out_valid}, 32'h0);
        chk({tag, "_q"}, {16'h0, q}, 32'h0);
        chk({tag, "_cout"}, {31'h0, cout}, 32'h0);
        chk({tag, "_ovf"}, {31'h0, ovf}, 32'h0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        sub      = 1'b0;
        #1;
        chk_zero("reset");
        #11 rst_n = 1'b1;
        idle(2);

        // Basic add, isolated so latency is visible alone
        op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
        idle(6);
        // Back-to-back directed vectors
        op(16'h000F, 16'h000F, 1'b0, 1'b0, 16'h001E, 1'b0, 1'b0);
        op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        op(16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        op(16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        idle(6);

        // Streaming with bubbles: 1,1,0,1,0,0,1 and alternating sub
        op(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        op(16'h5000, 16'h1000, 1'b0, 1'b1, 16'h4000, 1'b1, 1'b0);
        idle(1);
        op(16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);
        idle(2);
        op(16'h0100, 16'h0200, 1'b0, 1'b1, 16'hFF00, 1'b0, 1'b0);
        idle(8);

        // Reset mid-stream: three ops in flight are discarded
        drive(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        drive(16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        drive(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        sb.delete();
        last_q = '0;
        last_c = 1'b0;
        last_o = 1'b0;
        #1;
        chk_zero("midreset");
        #2 rst_n = 1'b1;
        idle(8);
        op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        idle(1);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        idle(2);
        chk("scoreboard_drained", sb.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adder_ripple_pipe.md
# adder_ripple_pipe

Parametrised, pipelined ripple-carry adder/subtractor. It generalises the team's 4-bit combinational ripple adder to WIDTH bits. The carry chain is cut into CHUNK-bit segments, with one register stage per segment, so one operation is accepted every cycle at a fixed latency of WIDTH/CHUNK cycles. It sits between operand registers and the datapath result bus, and supplies carry-out and signed overflow to downstream status logic.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per pipeline stage; STAGES = WIDTH/CHUNK (derived, ≥1).
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands on a/b/cin/sub are valid this cycle.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add mode; ignored when sub=1.
- sub  input  1  0: q = a + b + cin; 1: q = a − b (a + ~b + 1).
- out_valid  output  1  q/cout/ovf hold a new result this cycle.
- q  output  WIDTH  sum/difference, modulo 2^WIDTH.
- cout  output  1  carry out of MSB (in sub mode, 1 = no borrow).
- ovf  output  1  signed overflow: operand MSBs (after the b-inversion in sub mode) are equal and differ from the q MSB.

## Operation
- Capture edge: on a rising edge with in_valid=1, stage 0 registers three things: the sum of bits [CHUNK−1:0] with carry-in (cin, or 1 when sub=1); the carry out of that chunk; and the not-yet-added upper operand bits (b already inverted when sub=1).
- Stage i (1..STAGES−1) adds chunk i using the registered carry from stage i−1. It passes the completed lower sum bits forward and keeps the remaining upper operand bits aligned.
- A valid bit travels with each stage. A stage's data registers load only when its incoming valid is 1. Bubbles never corrupt data held in later stages.
- Outputs come from the final stage registers. When out_valid=0, q/cout/ovf hold the last valid result.
- ovf is computed in the last stage from the registered MSB of a, the registered MSB of the effective b, and the MSB of q.
- STAGES=1 degenerates to a single registered adder: latency 1, same port behaviour.
- There is no backpressure. The block accepts every cycle, and results must be consumed when out_valid=1.
- Arithmetic wraps modulo 2^WIDTH. cout is the only carry indication.

## Timing
- Latency: inputs captured at edge k appear with out_valid=1 during the cycle after edge k+STAGES−1, i.e. STAGES cycles.
- Throughput: 1 result per cycle. Any pattern of in_valid gaps is reproduced exactly on out_valid, delayed by STAGES cycles.
- Reset (rst_n=0, asynchronous): all stage valids, out_valid, q, cout and ovf go to 0 immediately. Intermediate data registers reset to 0.
- Reset mid-operation: every in-flight operation is discarded, and no out_valid pulse appears for it after release.
- First capture after release: the first rising edge with rst_n=1 and in_valid=1 is a normal capture edge.
- Mode per operation: sub and cin are sampled with a/b at the capture edge. Operations in flight are unaffected by later mode changes.
- Combinational depth per stage: one CHUNK-bit ripple plus the carry register. There is no path from input to output within a cycle.

## Test plan
All scenarios use WIDTH=16, CHUNK=4, so STAGES=4.

- Basic add: a=0x0001, b=0x0001, cin=0, sub=0 at edge 0 → out_valid=1 in the cycle after edge 3, q=0x0002, cout=0, ovf=0. Also a=0x000F, b=0x000F → q=0x001E.
- Full carry ripple: a=0xFFFF, b=0x0001 → q=0x0000, cout=1, ovf=0. Then a=0x0FFF, b=0x0001 → q=0x1000. Then a=0xFFFF, b=0x0000, cin=1 → q=0x0000, cout=1.
- Signed overflow: a=0x7FFF, b=0x0001 → q=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 → q=0x0000, cout=1, ovf=1.
- Subtract: sub=1, a=0x0003, b=0x0005, cin=1 (ignored) → q=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001 → q=0x7FFF, cout=1, ovf=1.
- Streaming with bubbles: in_valid pattern 1,1,0,1,0,0,1 with distinct operands and alternating sub → out_valid shows the identical pattern 4 cycles later, each q matches its operands, and q holds through the gaps.
- Reset mid-stream: issue 3 back-to-back ops, then pulse rst_n low for half a cycle before the first result emerges → outputs drop to 0 at once, no out_valid appears for those ops, and a new op issued after release returns correctly 4 cycles later.
